// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared widths, reset PC and fetch-path types for the 12-bit
//                CPU.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int          ADDR_WIDTH = 12;
    localparam int          DATA_WIDTH = 12;
    localparam int unsigned RESET_PC   = 0;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    // One buffered instruction together with the address it came from
    typedef struct packed {
        word_t instr;
        addr_t pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous circular FIFO of fetch entries with push, pop,
//                clear, occupancy count and a registered-storage head output.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 3,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_push,
    input  fetch_entry_t     i_push_data,
    input  logic             i_pop,
    output logic [CNT_W-1:0] o_count,
    output fetch_entry_t     o_head
);

    localparam int              c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   c_full = CNT_W'(DEPTH);

    fetch_entry_t         r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two
    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_last) ? '0 : p + 1'b1;
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != c_full) || w_do_pop);

    // Storage, pointers and count; clear empties the buffer without wiping data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Drives the instruction-side read
//                port of unified memory from a PC, captures the registered
//                read data a cycle later and buffers it for decode. Handles
//                redirects from execute and yields the port when ungranted.
//                ADDR_WIDTH/DATA_WIDTH must match the cpu_pkg entry type.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int          ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
    parameter int          DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int unsigned RESET_PC   = cpu_pkg::RESET_PC,
    parameter int          FIFO_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_grant,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc
);

    import cpu_pkg::*;

    localparam int                    c_cnt_w    = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] c_reset_pc = ADDR_WIDTH'(RESET_PC);
    localparam logic [c_cnt_w:0]      c_depth    = (c_cnt_w + 1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_req;
    logic [ADDR_WIDTH-1:0] r_req_pc;

    logic [c_cnt_w-1:0]    w_count;
    logic [c_cnt_w-1:0]    w_eff_count;
    logic                  w_eff_inflight;
    logic [c_cnt_w:0]      w_outstanding;
    logic                  w_push;
    logic                  w_pop;
    fetch_entry_t          w_push_data;
    fetch_entry_t          w_head;

    // A redirect flushes both the buffer and the in-flight read, so neither
    // reserves space against the fetch issued in the redirect cycle.
    assign w_eff_count    = redirect_valid ? '0   : w_count;
    assign w_eff_inflight = redirect_valid ? 1'b0 : r_req;
    assign w_outstanding  = {1'b0, w_eff_count} + (c_cnt_w + 1)'(w_eff_inflight);

    // Issue only when every outstanding word is guaranteed a buffer slot;
    // decode readiness is deliberately not part of this path.
    assign mem_addr = rst ? c_reset_pc : (redirect_valid ? redirect_pc : r_pc);
    assign mem_req  = mem_grant && !rst && (w_outstanding < c_depth);

    // Data returned for a read issued last cycle; dropped if a redirect lands now
    assign w_push      = r_req && !redirect_valid;
    assign w_push_data = '{instr: mem_rdata, pc: r_req_pc};

    assign instr_valid = (w_count != '0);
    assign w_pop       = instr_valid && instr_ready;
    assign instr       = w_head.instr;
    assign instr_pc    = w_head.pc;

    // PC and in-flight tracking; redirect reloads the PC even without a grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= c_reset_pc;
            r_req    <= 1'b0;
            r_req_pc <= '0;
        end else if (mem_req) begin
            r_pc     <= mem_addr + ADDR_WIDTH'(1);
            r_req    <= 1'b1;
            r_req_pc <= mem_addr;
        end else begin
            r_req <= 1'b0;
            if (redirect_valid) begin
                r_pc <= redirect_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (redirect_valid),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head      (w_head)
    );

endmodule
`default_nettype wire
